// File: rtl/mul8s_acc.sv
// -----------------------------------------------------------------------------
// mul8s_acc -- signed accumulator for the 16-bit products of an 8x8 signed
// approximate multiplier.
//
// A start pulse in IDLE loads a beat count (len). The block then takes that
// many products over a valid/ready handshake and adds each product to a
// signed ACC_W-bit accumulator. After the last beat it presents the sum and a
// sticky overflow flag on a valid/ready result port until the consumer
// accepts them.
//
// Configuration macro:
//   MUL8S_ACC_SAT_EN  defined   -> on overflow the accumulator clamps to the
//                                  most positive or most negative ACC_W value,
//                                  chosen by the sign of the true sum.
//                     undefined -> the accumulator wraps modulo 2^ACC_W.
//   In both builds out_ovf reports that an overflow happened.
//
// Parameters:
//   ACC_W      accumulator width in bits, legal range 17..32 (default 24)
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle request to begin an accumulation (IDLE only)
//   len        in   [7:0] number of products to accumulate, sampled with start
//   in_valid   in   in_p holds a valid product beat
//   in_ready   out  block accepts a beat this cycle (high only in ACC)
//   in_p       in   [15:0] signed product
//   out_valid  out  out_acc / out_ovf hold a valid result (high only in DONE)
//   out_ready  in   consumer takes the result this cycle
//   out_acc    out  [ACC_W-1:0] signed accumulated sum
//   out_ovf    out  signed overflow occurred at some beat of this accumulation
// -----------------------------------------------------------------------------
module mul8s_acc #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Extremes of the signed ACC_W range, used as clamp targets.
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [7:0]       cnt_q,   cnt_d;
  logic             ovf_q,   ovf_d;

  // One guard bit above the accumulator holds the exact sum of two ACC_W-bit
  // signed values, so overflow is visible as a disagreement between the top
  // two bits of that sum.
  logic [ACC_W:0]   sum_ext;
  logic             sum_ovf;
  logic [ACC_W-1:0] sum_next;
  logic             beat_acc;

  // ---------------------------------------------------------------------------
  // Datapath: add the sign-extended product and resolve overflow
  // ---------------------------------------------------------------------------
  always_comb begin
    sum_ext = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-16){in_p[15]}}, in_p};
    sum_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
`ifdef MUL8S_ACC_SAT_EN
    // The guard bit is the sign of the true sum, so it picks the clamp rail.
    if (sum_ovf) begin
      sum_next = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_next = sum_ext[ACC_W-1:0];
    end
`else
    // Dropping the guard bit is exactly a modulo-2^ACC_W wrap.
    sum_next = sum_ext[ACC_W-1:0];
`endif
  end

  // A beat is taken only while in ACC; in_ready is derived from the same state.
  assign beat_acc = in_valid && (state_q == S_ACC);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = len;
          // An empty accumulation goes straight to presenting a zero result.
          state_d = (len == 8'd0) ? S_DONE : S_ACC;
        end
      end

      S_ACC: begin
        // start is deliberately ignored here; len is not re-sampled.
        if (beat_acc) begin
          acc_d = sum_next;
          ovf_d = ovf_q | sum_ovf;   // sticky until the next start
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // Result registers hold still until the consumer takes them.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: straight from registers, so reset clears them immediately.
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_DONE);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mul8s_acc.sv
// -----------------------------------------------------------------------------
// tb_mul8s_acc -- directed self-checking bench for mul8s_acc.
//
// Two instances share every input: u_dut24 (ACC_W=24) and u_dut17 (ACC_W=17).
// The narrow one exercises overflow at the smallest legal width; expected
// values for it depend on MUL8S_ACC_SAT_EN.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled
// before the next rising edge.
// -----------------------------------------------------------------------------
module tb_mul8s_acc;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [15:0] in_p;
  logic        out_ready;

  logic               in_ready24, out_valid24, out_ovf24;
  logic signed [23:0] out_acc24;
  logic               in_ready17, out_valid17, out_ovf17;
  logic signed [16:0] out_acc17;

  int n_checks;
  int n_fail;

  mul8s_acc #(.ACC_W(24)) u_dut24 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready24),
    .in_p      (in_p),
    .out_valid (out_valid24),
    .out_ready (out_ready),
    .out_acc   (out_acc24),
    .out_ovf   (out_ovf24)
  );

  mul8s_acc #(.ACC_W(17)) u_dut17 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready17),
    .in_p      (in_p),
    .out_valid (out_valid17),
    .out_ready (out_ready),
    .out_acc   (out_acc17),
    .out_ovf   (out_ovf17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, act, act, exp, exp);
    end
  endtask

  // Advance one clock: the edge samples the current inputs, then settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
    len   = 8'hAA;
  endtask

  task automatic beat(input logic signed [15:0] p);
    in_valid = 1'b1;
    in_p     = p;
    tick();
    in_valid = 1'b0;
    in_p     = 16'h5A5A;
  endtask

  initial begin
    int idle_ok;
    int ready_ok;
    int stable_ok;
    logic signed [15:0] last_p;
    logic signed [31:0] exp17, exp24;

    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    in_p      = 16'd0;
    out_ready = 1'b1;

    // ---- reset state --------------------------------------------------------
    #2;
    check("rst_in_ready",  in_ready24,  0);
    check("rst_out_valid", out_valid24, 0);
    check("rst_out_acc",   out_acc24,   0);
    check("rst_out_ovf",   out_ovf24,   0);
    #21 rst_n = 1'b1;   // release away from an edge
    tick();
    check("idle_in_ready", in_ready24, 0);

    // ---- len=3, beats 100, -50, 7 back to back -----------------------------
    do_start(8'd3);
    check("acc3_in_ready", in_ready24, 1);
    check("acc3_no_valid", out_valid24, 0);
    in_valid = 1'b1;
    in_p = 16'sd100; tick();
    in_p = -16'sd50; tick();
    in_p = 16'sd7;   tick();
    in_valid = 1'b0;
    check("acc3_out_valid", out_valid24, 1);
    check("acc3_in_ready_lo", in_ready24, 0);
    check("acc3_out_acc", out_acc24, 57);
    check("acc3_out_ovf", out_ovf24, 0);
    tick();   // out_ready=1: consumed
    check("acc3_back_idle", out_valid24, 0);

    // ---- len=0: empty accumulation -----------------------------------------
    do_start(8'd0);
    check("len0_out_valid", out_valid24, 1);
    check("len0_in_ready",  in_ready24,  0);
    check("len0_out_acc",   out_acc24,   0);
    check("len0_out_ovf",   out_ovf24,   0);
    tick();
    check("len0_back_idle", out_valid24, 0);

    // ---- len=2 with input gaps, consumer stall, ignored start pulses -------
    out_ready = 1'b0;
    do_start(8'd2);
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      len   = 8'd7;
      tick();
    end
    start = 1'b0;
    check("gap_acc_hold0", out_acc24, 0);
    check("gap_in_ready",  in_ready24, 1);
    beat(16'sd1000);
    for (int i = 0; i < 3; i++) begin
      start = (i == 0);
      len   = 8'd1;
      tick();
    end
    start = 1'b0;
    check("gap_acc_hold1", out_acc24, 1000);
    check("gap_still_acc", in_ready24, 1);
    beat(16'sd2000);
    stable_ok = 1;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = 8'd9;
      if (out_valid24 !== 1'b1 || out_acc24 !== 24'sd3000 || out_ovf24 !== 1'b0)
        stable_ok = 0;
      tick();
    end
    start = 1'b0;
    check("stall_stable", stable_ok, 1);
    check("stall_out_acc", out_acc24, 3000);
    out_ready = 1'b1;
    tick();
    check("stall_released", out_valid24, 0);

    // ---- overflow at ACC_W=17: 32767 x3 = 98301 -----------------------------
    // 17-bit range is -65536..65535. Wrapped: 98301 - 131072 = -32771 (0x17FFD).
    do_start(8'd3);
    in_valid = 1'b1;
    in_p = 16'sd32767; tick();
    check("ovf_beat1_no_ovf", out_ovf17, 0);
    tick();
    check("ovf_beat2_no_ovf", out_ovf17, 0);
    tick();
    in_valid = 1'b0;
`ifdef MUL8S_ACC_SAT_EN
    check("ovf17_out_acc", out_acc17, 65535);
`else
    check("ovf17_out_acc", out_acc17, -32771);
`endif
    check("ovf17_out_ovf", out_ovf17, 1);
    check("ovf24_out_acc", out_acc24, 98301);
    check("ovf24_out_ovf", out_ovf24, 0);
    tick();

    // ---- sticky overflow: a non-overflowing beat after one that overflowed --
    // SAT: 65535 - 32768 = 32767. Wrap: -32771 + 32767 = -4.
`ifdef MUL8S_ACC_SAT_EN
    last_p = -16'sd32768;
    exp17  = 32767;
    exp24  = 65533;
`else
    last_p = 16'sd32767;
    exp17  = -4;
    exp24  = 131068;
`endif
    do_start(8'd4);
    in_valid = 1'b1;
    in_p = 16'sd32767; tick(); tick(); tick();
    in_p = last_p;     tick();
    in_valid = 1'b0;
    check("sticky17_out_acc", out_acc17, exp17);
    check("sticky17_out_ovf", out_ovf17, 1);
    check("sticky24_out_acc", out_acc24, exp24);
    tick();

    // ---- next start clears ovf ----------------------------------------------
    do_start(8'd1);
    check("restart_ovf_clr", out_ovf17, 0);
    beat(-16'sd3);
    check("restart_out_acc", out_acc17, -3);
    tick();

    // ---- len=255, all beats -32768 -----------------------------------------
    do_start(8'd255);
    ready_ok = 1;
    in_valid = 1'b1;
    in_p     = 16'h8000;
    for (int i = 0; i < 255; i++) begin
      if (in_ready24 !== 1'b1) ready_ok = 0;
      tick();
    end
    in_valid = 1'b0;
    check("len255_ready_all", ready_ok, 1);
    check("len255_in_ready_lo", in_ready24, 0);
    check("len255_out_valid", out_valid24, 1);
    check("len255_out_acc", out_acc24, -8355840);
    check("len255_out_ovf", out_ovf24, 0);
    check("len255_ovf17", out_ovf17, 1);
    tick();

    // ---- asynchronous reset mid-ACC -----------------------------------------
    do_start(8'd5);
    beat(16'sd1234);
    beat(16'sd1);
    check("pre_rst_acc", out_acc24, 1235);
    #3 rst_n = 1'b0;   // between edges
    #1;
    check("arst_in_ready",  in_ready24,  0);
    check("arst_out_valid", out_valid24, 0);
    check("arst_out_acc",   out_acc24,   0);
    check("arst_out_ovf",   out_ovf24,   0);
    #12 rst_n = 1'b1;
    tick();
    idle_ok = (in_ready24 === 1'b0 && out_valid24 === 1'b0) ? 1 : 0;
    check("post_rst_idle", idle_ok, 1);
    do_start(8'd1);
    beat(16'sd5);
    check("post_rst_valid", out_valid24, 1);
    check("post_rst_acc", out_acc24, 5);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
